// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared thermostat frame constants, field offsets and encoder state type
//
// Used by serial_encode (transmitter) and serial_decode (receiver) so both
// sides agree on the frame layout. The frame is 192 bits, sent MSB first.
package serial_frame_pkg;

    localparam int FRAME_BITS = 192;

    localparam logic [31:0] PREAMBLE = 32'hAAAAAAAA;
    localparam logic [15:0] TYPE_1   = 16'hD391;
    localparam logic [15:0] TYPE_2   = 16'hD391;
    localparam logic [31:0] CONSTANT = 32'h0DFFFFFE;

    // Field bit positions within the 192-bit frame.
    localparam int PREAMBLE_MSB = 191;
    localparam int PREAMBLE_LSB = 160;
    localparam int TYPE_1_MSB   = 159;
    localparam int TYPE_1_LSB   = 144;
    localparam int TYPE_2_MSB   = 143;
    localparam int TYPE_2_LSB   = 128;
    localparam int CONSTANT_MSB = 127;
    localparam int CONSTANT_LSB = 96;
    localparam int ID_MSB       = 95;
    localparam int ID_LSB       = 64;
    localparam int ROOM_MSB     = 63;
    localparam int ROOM_LSB     = 48;
    localparam int SET_MSB      = 47;
    localparam int SET_LSB      = 32;
    localparam int STATE_MSB    = 31;
    localparam int STATE_LSB    = 24;
    localparam int TAIL_1_MSB   = 23;
    localparam int TAIL_1_LSB   = 16;
    localparam int TAIL_2_MSB   = 15;
    localparam int TAIL_2_LSB   = 8;
    localparam int TAIL_3_MSB   = 7;
    localparam int TAIL_3_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    // Assemble a full frame from the variable fields plus fixed header.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [31:0] thermostat_id,
        input logic [15:0] room_temp,
        input logic [15:0] set_temp,
        input logic [7:0]  state,
        input logic [7:0]  tail_1,
        input logic [7:0]  tail_2,
        input logic [7:0]  tail_3
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[PREAMBLE_MSB:PREAMBLE_LSB] = PREAMBLE;
        f[TYPE_1_MSB:TYPE_1_LSB]     = TYPE_1;
        f[TYPE_2_MSB:TYPE_2_LSB]     = TYPE_2;
        f[CONSTANT_MSB:CONSTANT_LSB] = CONSTANT;
        f[ID_MSB:ID_LSB]             = thermostat_id;
        f[ROOM_MSB:ROOM_LSB]         = room_temp;
        f[SET_MSB:SET_LSB]           = set_temp;
        f[STATE_MSB:STATE_LSB]       = state;
        f[TAIL_1_MSB:TAIL_1_LSB]     = tail_1;
        f[TAIL_2_MSB:TAIL_2_LSB]     = tail_2;
        f[TAIL_3_MSB:TAIL_3_LSB]     = tail_3;
        return f;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - bit period counter for the serial frame transmitter
//
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   clear      in   hold the counter at zero
//   period_end out  high on the last clock of each bit period
module serial_bit_timer #(
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic period_end
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wraps at LAST so the counter never runs past its terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With CLOCKS_PER_BIT=1 this is constantly high; the caller gates it.
    assign period_end = (cnt_q == LAST);

endmodule

// File: rtl/serial_encode.sv
// rtl/serial_encode.sv - thermostat frame serial transmitter
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   frame_valid/frame_ready handshake accepting one frame's variable fields
//   thermostat_id .. tail_3 variable frame fields, sampled on the accept edge
//   busy                    frame in transmission
//   done                    one-cycle pulse after the last bit period
//   serial_data             current frame bit, MSB first
//   serial_clock            one-cycle strobe on the last clock of each bit
module serial_encode
    import serial_frame_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [31:0] thermostat_id,
    input  logic [15:0] room_temp,
    input  logic [15:0] set_temp,
    input  logic [7:0]  state,
    input  logic [7:0]  tail_1,
    input  logic [7:0]  tail_2,
    input  logic [7:0]  tail_3,
    output logic        busy,
    output logic        done,
    output logic        serial_data,
    output logic        serial_clock
);

    localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);

    enc_state_e            state_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [7:0]            bit_q;
    logic                  period_end;
    logic                  strobe;

    // Counter only runs in SEND, so each frame starts on a fresh period.
    serial_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (state_q != ST_SEND),
        .period_end(period_end)
    );

    assign strobe = period_end && (state_q == ST_SEND);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_valid) begin
                        shift_q <= build_frame(thermostat_id, room_temp, set_temp,
                                               state, tail_1, tail_2, tail_3);
                        bit_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (strobe) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                        if (bit_q == LAST_BIT) begin
                            state_q <= ST_DONE;
                        end else begin
                            bit_q <= bit_q + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches them directly.
    assign frame_ready  = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_SEND);
    assign done         = (state_q == ST_DONE);
    assign serial_data  = busy && shift_q[FRAME_BITS-1];
    assign serial_clock = strobe;

endmodule
